// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester round-robin front end for one shared
//               combinational ALU. One operation is in flight at a time:
//               accept (IDLE) -> execute (EXEC) -> hold result (RESP).
//               The result is held until the granted requester takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int CTL_W = 7
) (
    input  logic             clk,
    input  logic             reset,

    // Requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CTL_W-1:0] req0_ctl,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,

    // Requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [CTL_W-1:0] req1_ctl,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,

    // Shared response payload, qualified by rsp0_valid / rsp1_valid
    output logic [31:0]      rsp_data,
    output logic             rsp_branch,

    // Shared ALU
    output logic [CTL_W-1:0] alu_ctl,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_out,
    input  logic             alu_branch,

    output logic             busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // Control word parked on the ALU out of reset: AND, branch unused.
    localparam logic [CTL_W-1:0] c_CTL_RST = CTL_W'(7'b0100000);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_last_grant;   // requester served most recently
    logic             r_grant_id;     // requester owning the in-flight op
    logic [CTL_W-1:0] r_ctl;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_rsp_data;
    logic             r_rsp_branch;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic w_idle;
    logic w_win0;
    logic w_win1;
    logic w_accept0;
    logic w_accept1;
    logic w_accept;
    logic w_rsp_done;

    // Offers are only made in IDLE and never while reset is asserted, so a
    // request cannot slip in during the reset cycle.
    assign w_idle = (r_state == c_IDLE) && !reset;

    // On a tie the requester that was not served last wins. After reset
    // r_last_grant is 1, so requester 0 wins the first tie.
    assign w_win0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_win1 = req1_valid && (!req0_valid || !r_last_grant);

    assign req0_ready = w_idle && w_win0;
    assign req1_ready = w_idle && w_win1;

    assign w_accept0 = req0_valid && req0_ready;
    assign w_accept1 = req1_valid && req1_ready;
    assign w_accept  = w_accept0 || w_accept1;

    // ------------------------------------------------------------------------
    // Response handshake
    // ------------------------------------------------------------------------
    // Only the granted requester sees valid; the other one's ready is
    // therefore never part of a completed handshake.
    assign rsp0_valid = !reset && (r_state == c_RESP) && !r_grant_id;
    assign rsp1_valid = !reset && (r_state == c_RESP) &&  r_grant_id;

    assign w_rsp_done = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign rsp_data   = r_rsp_data;
    assign rsp_branch = r_rsp_branch;

    // ------------------------------------------------------------------------
    // ALU drive: always from the operand registers so requesters may change
    // their inputs freely once accepted. During reset the control word is
    // forced to its parked value before the register has been initialised.
    // ------------------------------------------------------------------------
    assign alu_ctl = reset ? c_CTL_RST : r_ctl;
    assign alu_a   = r_a;
    assign alu_b   = r_b;

    assign busy = (r_state != c_IDLE);

    // ------------------------------------------------------------------------
    // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP unconditionally,
    // RESP -> IDLE on the granted requester's ready.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_EXEC;
                end
            end
            c_EXEC: begin
                w_state_nxt = c_RESP;
            end
            c_RESP: begin
                if (w_rsp_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // State register; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping: grant_id on accept, last_grant on response handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_accept) begin
                r_grant_id <= w_accept1;
            end
            if (w_rsp_done) begin
                r_last_grant <= r_grant_id;
            end
        end
    end

    // Operand registers: loaded from the winner on accept, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctl <= c_CTL_RST;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
        end else if (w_accept1) begin
            r_ctl <= req1_ctl;
            r_a   <= req1_a;
            r_b   <= req1_b;
        end else if (w_accept0) begin
            r_ctl <= req0_ctl;
            r_a   <= req0_a;
            r_b   <= req0_b;
        end
    end

    // Result capture in EXEC; held stable through RESP until the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_data   <= 32'd0;
            r_rsp_branch <= 1'b0;
        end else if (r_state == c_EXEC) begin
            r_rsp_data   <= alu_out;
            r_rsp_branch <= alu_branch;
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: CTL_W, default 7, the ALU control width, which matches the ALUctl encoding.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester N's operation is accepted this cycle.
REQ-006 req0_ctl / req1_ctl  input  CTL_W  ALU control for requester N.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  32  operands for requester N.
REQ-008 rsp0_valid / rsp1_valid  output  1  a result for requester N is held.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester N consumes the result.
REQ-010 rsp_data  output  32  result word, shared by both requesters and qualified by rspN_valid.
REQ-011 rsp_branch  output  1  captured Branch_Enable, qualified by rspN_valid.
REQ-012 alu_ctl  output  CTL_W  control driven to the shared ALU.
REQ-013 alu_a, alu_b  output  32  operands driven to the shared ALU.
REQ-014 alu_out  input  32  combinational result from the shared ALU.
REQ-015 alu_branch  input  1  combinational branch enable from the shared ALU.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The block SHALL implement a 3-state FSM: IDLE, EXEC, RESP.
REQ-018 In IDLE, the block SHALL select a winner among the asserted reqN_valid signals:
- If only one requester is valid, that requester wins.
- If both are valid, the requester that was not last_grant wins (round-robin).
REQ-019 reqN_ready SHALL be high only in IDLE, and only for the winner; it may combinationally depend on reqN_valid.
REQ-020 On acceptance (valid && ready), the block SHALL latch ctl, a and b into operand registers and record grant_id, then move to EXEC.
REQ-021 alu_ctl, alu_a and alu_b SHALL always be driven from the operand registers, never directly from the req ports.
REQ-022 In EXEC, the block SHALL capture alu_out into rsp_data and alu_branch into rsp_branch, then move to RESP.
REQ-023 In RESP, rsp[grant_id]_valid SHALL be high and the other rsp valid SHALL be low.
- rsp_data and rsp_branch SHALL hold stable until the handshake.
REQ-024 The RESP handshake SHALL behave as follows:
- On rsp[grant_id]_ready, the block moves to IDLE and sets last_grant = grant_id.
- Without ready, the block stays in RESP indefinitely.
REQ-025 No request SHALL be accepted in EXEC or RESP; the minimum accept-to-accept interval is 3 cycles.
REQ-026 Latency SHALL be as follows: acceptance in cycle T, EXEC in cycle T+1, rsp_valid first high in cycle T+2.
REQ-027 rspN_ready asserted while rspN_valid is low SHALL be ignored.
- rspN_ready of the non-granted requester SHALL be ignored.
REQ-028 A requester's ctl and operands MAY change after acceptance without affecting the in-flight result.
REQ-029 In IDLE, operand registers SHALL hold their last values; alu_ctl is not reset to idle between operations.
REQ-030 The 32-bit data SHALL pass through unmodified: no widening, truncation or sign change.

Reset
REQ-031 When reset is high at a clock edge, the block SHALL enter IDLE, set last_grant = 1 (requester 0 wins the first tie), and clear operands and rsp_data to 0 and rsp_branch to 0.
REQ-032 While reset is high or in the cycle after reset, alu_ctl SHALL equal 7'b0100000 (AND, branch unused).
REQ-033 A reset during EXEC or RESP SHALL discard the in-flight operation.
- No rsp valid is asserted afterwards.
- No acceptance occurs in the reset cycle.
REQ-034 While reset is high, all reqN_ready and rspN_valid outputs SHALL be 0.
- busy SHALL be 0 from the first cycle after reset.

Verification
REQ-035 Single request: req0 ctl=7'h22 (ADD), a=5, b=7, rsp0_ready held high -> req0_ready in cycle T, rsp0_valid in T+2 with rsp_data=12, then IDLE in T+3.
REQ-036 Tie after reset: both valid in the same cycle -> req0 is granted first; hold both valid -> req1 is granted next, then req0 (strict alternation, 3-cycle spacing).
REQ-037 Branch capture: req1 ctl=SUB with branch BEQ, a=b=0x1234 -> rsp1_valid with rsp_branch=1 and rsp_data=0; with a=0x1234, b=0x1235 -> rsp_branch=0.
REQ-038 Backpressure: rsp0_ready low for 10 cycles -> rsp0_valid and rsp_data stay stable, req1_ready stays 0 and busy stays 1; then ready goes high -> IDLE the next cycle.
REQ-039 Operand change after accept: a changes from 3 to 99 the cycle after acceptance of a=3, b=4, ADD -> rsp_data=7.
REQ-040 Reset in RESP: reset pulsed one cycle while rsp1_valid is high -> rsp1_valid=0 thereafter, busy=0, and the next tie goes to req0.
